// File: rtl/matmul_stream_core_pkg.sv
// Shared types, default widths and the saturating accumulate helper
// for the streaming matrix-multiply core.
package matmul_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;
  localparam int M_DEF      = 2;
  localparam int N_DEF      = 2;
  localparam int K_MAX_DEF  = 16;
  localparam int SAT_DEF    = 1;

  // Working width of sat_add; cells narrow the result to their own ACC_W (< SUM_W).
  localparam int SUM_W = 64;

  typedef enum logic [1:0] {IDLE, STREAM, OUT} state_t;

  typedef struct packed {
    logic signed [SUM_W-1:0] sum;
    logic                    ovf;
  } sat_res_t;

  // acc and prod arrive sign-extended; the range test is done against acc_w bits.
  function automatic sat_res_t sat_add(input logic signed [SUM_W-1:0] acc,
                                       input logic signed [SUM_W-1:0] prod,
                                       input int                      acc_w,
                                       input logic                    sat);
    logic signed [SUM_W:0] s;
    logic signed [SUM_W:0] hi;
    logic signed [SUM_W:0] lo;
    sat_res_t              r;
    s  = {acc[SUM_W-1], acc} + {prod[SUM_W-1], prod};
    hi = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (acc_w - 1));
    r.ovf = (s > hi) || (s < lo);
    if (sat && (s > hi))      r.sum = hi[SUM_W-1:0];
    else if (sat && (s < lo)) r.sum = lo[SUM_W-1:0];
    else                      r.sum = s[SUM_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/matmul_stream_core_if.sv
// Control, operand-stream and result signals of matmul_stream_core.
// master = the side feeding operands and consuming results, slave = the core.
interface matmul_stream_core_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int M      = 2,
  parameter int N      = 2,
  parameter int K_MAX  = 16
);
  localparam int KW = $clog2(K_MAX + 1);

  logic                    start;
  logic [KW-1:0]           k_len;
  logic                    accum;
  logic                    busy;
  logic                    op_valid;
  logic                    op_ready;
  logic [M*DATA_W-1:0]     a_col;
  logic [N*DATA_W-1:0]     b_row;
  logic [KW-1:0]           k_idx;
  logic                    c_valid;
  logic                    c_ready;
  logic [M*N*ACC_W-1:0]    c;
  logic                    ovf;

  modport master (
    output start, k_len, accum, op_valid, a_col, b_row, c_ready,
    input  busy, op_ready, k_idx, c_valid, c, ovf
  );

  modport slave (
    input  start, k_len, accum, op_valid, a_col, b_row, c_ready,
    output busy, op_ready, k_idx, c_valid, c, ovf
  );
endinterface

// File: rtl/matmul_stream_core_mac_cell.sv
// One output-stationary accumulator: acc += a*b per enabled beat, with
// synchronous clear and a sticky per-cell overflow bit.
module mac_cell import matmul_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter bit SAT    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [ACC_W-1:0]  o_acc,
  output logic                     o_ovf
);

  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_ovf;
  logic signed [2*DATA_W-1:0] w_prod;
  sat_res_t                   w_res;
  logic [SUM_W-ACC_W-1:0]     w_unused_hi;
  logic [ACC_W-1:0]           w_acc_next;

  assign w_prod = i_a * i_b;
  assign w_res  = sat_add({{(SUM_W-ACC_W){r_acc[ACC_W-1]}}, r_acc},
                          {{(SUM_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod},
                          ACC_W, SAT);
  // Bits above ACC_W are discarded: wrap mode keeps only the low ACC_W bits.
  assign {w_unused_hi, w_acc_next} = w_res.sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      r_acc <= w_acc_next;
      if (w_res.ovf) r_ovf <= 1'b1;
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/matmul_stream_core.sv
// Output-stationary M x N matrix-multiply engine: one k-slice per beat,
// runtime tile length up to K_MAX, result held until accepted.
module matmul_stream_core import matmul_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int M      = M_DEF,
  parameter int N      = N_DEF,
  parameter int K_MAX  = K_MAX_DEF,
  parameter int SAT    = SAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  matmul_stream_core_if.slave  bus
);

  localparam int KW = $clog2(K_MAX + 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [KW-1:0]   r_k_idx;
  logic [KW-1:0]   r_k_len;
  logic [KW-1:0]   w_k_len_in;
  logic            w_start;
  logic            w_beat;
  logic            w_last;
  logic            w_clr;
  logic [M*N-1:0]  w_cell_ovf;

  assign w_k_len_in = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
  assign w_start    = (r_state == IDLE) && bus.start;
  assign w_beat     = (r_state == STREAM) && bus.op_valid;
  assign w_last     = (r_k_idx == r_k_len - KW'(1));
  assign w_clr      = w_start && !bus.accum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = (w_k_len_in == '0) ? OUT : STREAM;
      STREAM:  if (w_beat && w_last) w_state_next = OUT;
      OUT:     if (bus.c_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (r_state != IDLE);
    bus.op_ready = (r_state == STREAM);
    bus.c_valid  = (r_state == OUT);
  end

  // k_idx parks on k_len-1 after the last beat until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k_idx <= '0;
      r_k_len <= '0;
    end else if (w_start) begin
      r_k_idx <= '0;
      r_k_len <= w_k_len_in;
    end else if (w_beat && !w_last) begin
      r_k_idx <= r_k_idx + KW'(1);
    end
  end

  assign bus.k_idx = r_k_idx;

  genvar gi, gj;
  generate
    for (gi = 0; gi < M; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        mac_cell #(
          .DATA_W (DATA_W),
          .ACC_W  (ACC_W),
          .SAT    (SAT != 0)
        ) u_cell (
          .clk    (clk),
          .rst    (rst),
          .i_clr  (w_clr),
          .i_en   (w_beat),
          .i_a    (bus.a_col[gi*DATA_W +: DATA_W]),
          .i_b    (bus.b_row[gj*DATA_W +: DATA_W]),
          .o_acc  (bus.c[(gi*N+gj)*ACC_W +: ACC_W]),
          .o_ovf  (w_cell_ovf[gi*N+gj])
        );
      end
    end
  endgenerate

  assign bus.ovf = |w_cell_ovf;

endmodule

// File: tb/tb_matmul_stream_core.sv
// Directed self-checking bench for matmul_stream_core: a 32-bit saturating
// instance plus 16-bit saturating and wrapping instances for overflow cases.
module tb_matmul_stream_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matmul_stream_core_if #(.DATA_W(8), .ACC_W(32), .M(2), .N(2), .K_MAX(16)) m_if ();
  matmul_stream_core_if #(.DATA_W(8), .ACC_W(16), .M(2), .N(2), .K_MAX(16)) s_if ();
  matmul_stream_core_if #(.DATA_W(8), .ACC_W(16), .M(2), .N(2), .K_MAX(16)) w_if ();

  matmul_stream_core #(.DATA_W(8), .ACC_W(32), .M(2), .N(2), .K_MAX(16), .SAT(1)) u_dut (
    .clk (clk), .rst (rst), .bus (m_if));
  matmul_stream_core #(.DATA_W(8), .ACC_W(16), .M(2), .N(2), .K_MAX(16), .SAT(1)) u_sat16 (
    .clk (clk), .rst (rst), .bus (s_if));
  matmul_stream_core #(.DATA_W(8), .ACC_W(16), .M(2), .N(2), .K_MAX(16), .SAT(0)) u_wrap16 (
    .clk (clk), .rst (rst), .bus (w_if));

  // Both 16-bit instances see identical stimulus.
  logic        s_start, s_accum, s_valid, s_c_ready;
  logic [4:0]  s_k_len;
  logic [15:0] s_a, s_b;
  assign s_if.start = s_start;   assign w_if.start = s_start;
  assign s_if.k_len = s_k_len;   assign w_if.k_len = s_k_len;
  assign s_if.accum = s_accum;   assign w_if.accum = s_accum;
  assign s_if.op_valid = s_valid; assign w_if.op_valid = s_valid;
  assign s_if.a_col = s_a;       assign w_if.a_col = s_a;
  assign s_if.b_row = s_b;       assign w_if.b_row = s_b;
  assign s_if.c_ready = s_c_ready; assign w_if.c_ready = s_c_ready;

  int n_total = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] mc(input int idx);
    return $signed(m_if.c[idx*32 +: 32]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input int a0, input int a1, input int b0, input int b1);
    m_if.a_col = {8'(a1), 8'(a0)};
    m_if.b_row = {8'(b1), 8'(b0)};
  endtask

  task automatic start_tile(input int klen, input logic acc);
    m_if.start = 1'b1;
    m_if.k_len = 5'(klen);
    m_if.accum = acc;
    tick();
    m_if.start = 1'b0;
  endtask

  task automatic beat(input int gap, input int a0, input int a1, input int b0, input int b1);
    m_if.op_valid = 1'b0;
    repeat (gap) tick();
    set_ab(a0, a1, b0, b1);
    m_if.op_valid = 1'b1;
    for (int w = 0; w < 20 && !m_if.op_ready; w++) tick();
    chk("beat_ready", m_if.op_ready, 1);
    tick();
    m_if.op_valid = 1'b0;
  endtask

  task automatic chk_c(input string tag, input int e0, input int e1, input int e2, input int e3);
    chk({tag, "_c00"}, mc(0), e0);
    chk({tag, "_c01"}, mc(1), e1);
    chk({tag, "_c10"}, mc(2), e2);
    chk({tag, "_c11"}, mc(3), e3);
  endtask

  task automatic tile1(input logic acc, input int g0, input int g1);
    start_tile(2, acc);
    beat(g0, 1, 3, 5, 6);
    beat(g1, 2, 4, 7, 8);
  endtask

  initial begin
    int beats;
    m_if.start = 0; m_if.k_len = 0; m_if.accum = 0; m_if.op_valid = 0;
    m_if.a_col = 0; m_if.b_row = 0; m_if.c_ready = 0;
    s_start = 0; s_accum = 0; s_valid = 0; s_c_ready = 0; s_k_len = 0; s_a = 0; s_b = 0;

    repeat (3) tick();
    chk("rst_busy", m_if.busy, 0);
    chk("rst_op_ready", m_if.op_ready, 0);
    chk("rst_c_valid", m_if.c_valid, 0);
    chk("rst_k_idx", m_if.k_idx, 0);
    chk("rst_ovf", m_if.ovf, 0);
    chk("rst_c00", mc(0), 0);
    rst = 1'b0;
    tick();

    // Basic 2-beat tile
    start_tile(2, 1'b0);
    chk("t1_busy", m_if.busy, 1);
    chk("t1_op_ready", m_if.op_ready, 1);
    chk("t1_k_idx0", m_if.k_idx, 0);
    beat(0, 1, 3, 5, 6);
    chk("t1_partial_c00", mc(0), 5);
    chk("t1_k_idx1", m_if.k_idx, 1);
    chk("t1_no_valid_yet", m_if.c_valid, 0);
    beat(0, 2, 4, 7, 8);
    chk("t1_c_valid", m_if.c_valid, 1);
    chk("t1_op_ready_out", m_if.op_ready, 0);
    chk_c("t1", 19, 22, 43, 50);
    chk("t1_ovf", m_if.ovf, 0);
    $display("tile basic: c00=%0d c11=%0d", mc(0), mc(3));

    // Result held while c_ready low; junk operands must not be taken
    set_ab(9, 9, 9, 9);
    m_if.op_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("hold_c_valid", m_if.c_valid, 1);
      chk("hold_c00", mc(0), 19);
      chk("hold_c11", mc(3), 50);
    end
    m_if.c_ready = 1'b1;
    tick();
    m_if.c_ready = 1'b0;
    chk("acc_c_valid", m_if.c_valid, 0);
    chk("acc_busy", m_if.busy, 0);
    tick();
    chk("idle_op_ready", m_if.op_ready, 0);
    chk("idle_c00", mc(0), 19);
    m_if.op_valid = 1'b0;
    $display("tile hold/accept: c_valid=%0d", m_if.c_valid);

    // Same tile with op_valid gaps
    tile1(1'b0, 2, 5);
    chk_c("gap", 19, 22, 43, 50);
    chk("gap_ovf", m_if.ovf, 0);
    m_if.c_ready = 1'b1;
    tick();
    $display("tile gaps: c00=%0d", mc(0));

    // Accumulate across tiles, c_ready held high in advance
    start_tile(2, 1'b1);
    beat(0, 1, 3, 5, 6);
    beat(0, 2, 4, 7, 8);
    chk("accum_c_valid", m_if.c_valid, 1);
    chk_c("accum", 38, 44, 86, 100);
    tick();
    chk("accum_out_1cyc", m_if.c_valid, 0);
    chk("accum_idle", m_if.busy, 0);
    $display("tile accum: c11=%0d", mc(3));

    // k_len = 0 with clear
    start_tile(0, 1'b0);
    chk("k0_c_valid", m_if.c_valid, 1);
    chk("k0_op_ready", m_if.op_ready, 0);
    chk_c("k0", 0, 0, 0, 0);
    tick();
    chk("k0_idle", m_if.busy, 0);
    m_if.c_ready = 1'b0;
    $display("tile k_len=0: c00=%0d", mc(0));

    // k_len above K_MAX clamps to 16 beats
    set_ab(1, 1, 1, 1);
    m_if.op_valid = 1'b1;
    start_tile(21, 1'b0);
    beats = 0;
    for (int w = 0; w < 40 && !m_if.c_valid; w++) begin
      if (m_if.op_ready) beats++;
      tick();
    end
    m_if.op_valid = 1'b0;
    chk("kmax_beats", beats, 16);
    chk("kmax_c_valid", m_if.c_valid, 1);
    chk("kmax_c00", mc(0), 16);
    chk("kmax_k_idx", m_if.k_idx, 15);
    m_if.c_ready = 1'b1;
    tick();
    m_if.c_ready = 1'b0;
    $display("tile k_len clamp: beats=%0d", beats);

    // Reset in the middle of a tile
    start_tile(2, 1'b0);
    beat(0, 1, 3, 5, 6);
    rst = 1'b1;
    #1;
    chk("mrst_busy", m_if.busy, 0);
    chk("mrst_op_ready", m_if.op_ready, 0);
    chk("mrst_c_valid", m_if.c_valid, 0);
    chk("mrst_k_idx", m_if.k_idx, 0);
    chk("mrst_c00", mc(0), 0);
    chk("mrst_ovf", m_if.ovf, 0);
    tick();
    rst = 1'b0;
    tick();
    tile1(1'b0, 0, 0);
    chk_c("post_rst", 19, 22, 43, 50);
    m_if.c_ready = 1'b1;
    tick();
    m_if.c_ready = 1'b0;
    $display("tile after mid-tile reset: c00=%0d", mc(0));

    // 16-bit saturate vs wrap: 3 x 127*127 = 48387
    s_a = {8'd127, 8'd127};
    s_b = {8'd127, 8'd127};
    s_k_len = 5'd3;
    s_accum = 1'b0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_valid = 1'b1;
    repeat (3) tick();
    s_valid = 1'b0;
    chk("sat_c_valid", s_if.c_valid, 1);
    chk("sat_c00", $signed(s_if.c[15:0]), 32767);
    chk("sat_c11", $signed(s_if.c[63:48]), 32767);
    chk("sat_ovf", s_if.ovf, 1);
    chk("wrap_c00", $signed(w_if.c[15:0]), -17149);
    chk("wrap_c11", $signed(w_if.c[63:48]), -17149);
    chk("wrap_ovf", w_if.ovf, 1);
    $display("tile 16b: sat=%0d wrap=%0d", $signed(s_if.c[15:0]), $signed(w_if.c[15:0]));
    s_c_ready = 1'b1;
    tick();
    s_c_ready = 1'b0;

    // A fresh accum=0 tile clears the sticky flag
    s_a = {8'd1, 8'd1};
    s_b = {8'd1, 8'd1};
    s_k_len = 5'd1;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("clr_sat_ovf", s_if.ovf, 0);
    chk("clr_wrap_ovf", w_if.ovf, 0);
    chk("clr_sat_c00", $signed(s_if.c[15:0]), 1);
    chk("clr_wrap_c00", $signed(w_if.c[15:0]), 1);
    $display("tile 16b clear: ovf=%0d/%0d", s_if.ovf, w_if.ovf);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
